// File: rtl/usb_tx_pkg.sv
// Shared constants for the USB full-speed transmit encoder: FSM encodings,
// the SYNC pattern and the {d_plus, d_minus} line states.
package usb_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// Ones-run counter, stuff request and NRZI level for the transmit path.
// `level` is the line level for the bit being strobed this cycle (1 = J).
module usb_nrzi_stuffer #(
  parameter int STUFF_LIMIT = 6
) (
  input  logic clk,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_strobe,
  output logic stuff_req,
  output logic level
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);

  logic [OW-1:0] ones;
  logic          level_q;
  logic          send_zero;

  assign stuff_req = (ones >= OW'(STUFF_LIMIT));
  // A pending stuff forces a 0 onto the line regardless of bit_in.
  assign send_zero = stuff_req || !bit_in;
  assign level     = (bit_strobe && send_zero) ? !level_q : level_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      ones    <= '0;
      level_q <= 1'b1;
    end else if (bit_strobe) begin
      level_q <= level;
      if (send_zero) ones <= '0;
      else           ones <= ones + 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first serialization with
// bit stuffing and NRZI, then SE0/SE0/J end of packet.
import usb_tx_pkg::*;

module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam logic [7:0] TICK_RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [2:0] state;
  logic [7:0] shreg;
  logic [7:0] hold;
  logic       hold_full;
  logic       last_seen;
  logic [3:0] bit_cnt;
  logic [7:0] tick;
  logic       eop_bit;
  logic [1:0] line;

  logic       accept, tick_zero, shifting, byte_done, have_byte;
  logic [7:0] next_byte;
  logic       strobe, bit_val, stuff_req, level, clear;

  assign tx_ready  = !hold_full && !last_seen;
  assign tx_busy   = (state != ST_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign tick_zero = (tick == '0);
  assign shifting  = ((state == ST_SYNC) || (state == ST_DATA)) && tick_zero;
  assign byte_done = (bit_cnt == 4'd8);
  // A byte accepted on the boundary edge itself goes straight to the shifter.
  assign next_byte = hold_full ? hold : tx_data;
  assign have_byte = hold_full || accept;
  assign clear     = rst || ((state == ST_EOP_SE0) && tick_zero && eop_bit);
  assign d_plus    = line[1];
  assign d_minus   = line[0];

  always_comb begin
    strobe  = 1'b0;
    bit_val = 1'b0;
    if ((state == ST_IDLE) && accept) begin
      strobe  = 1'b1;
      bit_val = SYNC_BYTE[0];
    end else if (shifting) begin
      if (stuff_req) begin
        strobe = 1'b1;
      end else if (!byte_done) begin
        strobe  = 1'b1;
        bit_val = shreg[0];
      end else if (have_byte) begin
        strobe  = 1'b1;
        bit_val = next_byte[0];
      end
    end
  end

  usb_nrzi_stuffer #(.STUFF_LIMIT(STUFF_LIMIT)) u_stuffer (
    .clk       (clk),
    .clear     (clear),
    .bit_in    (bit_val),
    .bit_strobe(strobe),
    .stuff_req (stuff_req),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      line      <= LINE_J;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      last_seen <= 1'b0;
      bit_cnt   <= '0;
      tick      <= '0;
      eop_bit   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      if (strobe) begin
        line <= level ? LINE_J : LINE_K;
        tick <= TICK_RELOAD;
      end else if (!tick_zero) begin
        tick <= tick - 1'b1;
      end
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        last_seen <= tx_last;
      end
      case (state)
        ST_IDLE: if (accept) begin
          state   <= ST_SYNC;
          shreg   <= SYNC_BYTE >> 1;
          bit_cnt <= 4'd1;
        end
        ST_SYNC, ST_DATA: if (shifting && !stuff_req) begin
          if (!byte_done) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 4'd1;
          end else if (have_byte) begin
            state     <= ST_DATA;
            shreg     <= next_byte >> 1;
            bit_cnt   <= 4'd1;
            hold_full <= 1'b0;
          end else begin
            // Underrun also sets last_seen so nothing is accepted during EOP.
            state     <= ST_EOP_SE0;
            line      <= LINE_SE0;
            tick      <= TICK_RELOAD;
            eop_bit   <= 1'b0;
            tx_err    <= !last_seen;
            last_seen <= 1'b1;
          end
        end
        ST_EOP_SE0: if (tick_zero) begin
          tick <= TICK_RELOAD;
          if (!eop_bit) begin
            eop_bit <= 1'b1;
          end else begin
            state <= ST_EOP_J;
            line  <= LINE_J;
          end
        end
        ST_EOP_J: if (tick_zero) begin
          state     <= ST_IDLE;
          last_seen <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder at CLKS_PER_BIT=8: line traces are
// captured once per clock and compared bit period by bit period.
module tb_usb_tx_encoder;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_err;

  int errors = 0;
  int checks = 0;

  logic [1:0] tr_line[$];
  logic       tr_busy[$];
  logic       tr_err[$];
  logic       tr_ready[$];

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(8), .STUFF_LIMIT(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .tx_busy (tx_busy),
    .tx_err  (tx_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; records n cycles of outputs.
  task automatic capture(input int n);
    tr_line.delete(); tr_busy.delete(); tr_err.delete(); tr_ready.delete();
    for (int i = 0; i < n; i++) begin
      tr_line.push_back({d_plus, d_minus});
      tr_busy.push_back(tx_busy);
      tr_err.push_back(tx_err);
      tr_ready.push_back(tx_ready);
      @(negedge clk);
    end
  endtask

  // Leaves the bench at the negedge of the first cycle after the accept edge.
  task automatic start_byte(input logic [7:0] d, input logic l);
    @(negedge clk);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA; tx_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({d_plus, d_minus, tx_ready, tx_busy, tx_err} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_outputs: dp,dm,ready,busy,err=%b expected 10100",
               {d_plus, d_minus, tx_ready, tx_busy, tx_err});
    end
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || {d_plus, d_minus} !== J) begin
      errors++;
      $display("FAIL reset_no_accept: busy=%b line=%b expected busy=0 line=%b",
               tx_busy, {d_plus, d_minus}, J);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_zero();
    logic [1:0] exp_l [0:18] = '{K,J,K,J,K,J,K,K, J,K,J,K,J,K,J,K, S,S,J};
    logic       any_err;
    start_byte(8'h00, 1'b1);
    capture(160);
    for (int b = 0; b < 19; b++) begin
      logic [1:0] bad = exp_l[b];
      for (int c = 0; c < 8; c++)
        if (tr_line[b*8+c] !== exp_l[b]) bad = tr_line[b*8+c];
      checks++;
      if (bad !== exp_l[b]) begin
        errors++;
        $display("FAIL zero_bit%0d: line=%b expected %b", b, bad, exp_l[b]);
      end
    end
    checks++;
    if (tr_busy[151] !== 1'b1 || tr_busy[152] !== 1'b0 || tr_ready[152] !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy_end: busy151=%b busy152=%b ready152=%b expected 1 0 1",
               tr_busy[151], tr_busy[152], tr_ready[152]);
    end
    any_err = 1'b0;
    foreach (tr_err[i]) if (tr_err[i] !== 1'b0) any_err = 1'b1;
    checks++;
    if (any_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_err: tx_err seen=%b expected 0", any_err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stuff_ff(input string tag);
    logic [1:0] exp_l [0:19] = '{K,J,K,J,K,J,K,K, K,K,K,K,K,J,J,J,J, S,S,J};
    start_byte(8'hFF, 1'b1);
    capture(168);
    for (int b = 0; b < 20; b++) begin
      logic [1:0] bad = exp_l[b];
      for (int c = 0; c < 8; c++)
        if (tr_line[b*8+c] !== exp_l[b]) bad = tr_line[b*8+c];
      checks++;
      if (bad !== exp_l[b]) begin
        errors++;
        $display("FAIL %s_bit%0d: line=%b expected %b", tag, b, bad, exp_l[b]);
      end
    end
    checks++;
    if (tr_busy[159] !== 1'b1 || tr_busy[160] !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: busy159=%b busy160=%b expected 1 0",
               tag, tr_busy[159], tr_busy[160]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [0:2] = '{8'hA5, 8'h3C, 8'h81};
    logic       got [$];
    logic [1:0] prev, v;
    int         idx, guard, ones, se0_bit;
    logic       steady, any_err;
    @(posedge clk); #1;
    idx = 0; guard = 0;
    fork
      begin
        while (idx < 3 && guard < 400) begin
          @(negedge clk); guard++;
          tx_data = bytes[idx]; tx_last = (idx == 2); tx_valid = 1'b1;
          if (tx_ready) idx++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        capture(320);
      end
    join
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("FAIL b2b_accepts: accepted=%0d expected 3", idx);
    end
    prev = J; ones = 0; steady = 1'b1; se0_bit = -1;
    for (int b = 0; b < 40 && se0_bit < 0; b++) begin
      v = tr_line[b*8+4];
      for (int c = 0; c < 8; c++) if (tr_line[b*8+c] !== v) steady = 1'b0;
      if (v === S) se0_bit = b;
      else begin
        if (ones == 6) ones = 0;
        else begin
          got.push_back(v === prev);
          ones = (v === prev) ? ones + 1 : 0;
        end
        prev = v;
      end
    end
    checks++;
    if (got.size() != 32 || se0_bit != 32) begin
      errors++;
      $display("FAIL b2b_length: bits=%0d se0_at=%0d expected 32 32", got.size(), se0_bit);
    end
    for (int n = 0; n < 4; n++) begin
      logic [7:0] val = '0;
      logic [7:0] want = (n == 0) ? 8'h80 : bytes[n-1];
      for (int k = 0; k < 8; k++) if (8*n+k < got.size()) val[k] = got[8*n+k];
      checks++;
      if (val !== want) begin
        errors++;
        $display("FAIL b2b_byte%0d: decoded=%h expected %h", n, val, want);
      end
    end
    checks++;
    if (steady !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bit_width: steady=%b expected 1", steady);
    end
    any_err = 1'b0;
    foreach (tr_err[i]) if (tr_err[i] !== 1'b0) any_err = 1'b1;
    checks++;
    if (any_err !== 1'b0 || tr_busy[279] !== 1'b1 || tr_busy[280] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: err=%b busy279=%b busy280=%b expected 0 1 0",
               any_err, tr_busy[279], tr_busy[280]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_underrun();
    logic se0_ok;
    start_byte(8'h12, 1'b0);
    capture(160);
    checks++;
    if (tr_err[127] !== 1'b0 || tr_err[128] !== 1'b1 || tr_err[129] !== 1'b0) begin
      errors++;
      $display("FAIL underrun_err_pulse: err127..129=%b%b%b expected 010",
               tr_err[127], tr_err[128], tr_err[129]);
    end
    se0_ok = 1'b1;
    for (int i = 128; i < 144; i++) if (tr_line[i] !== S) se0_ok = 1'b0;
    for (int i = 144; i < 152; i++) if (tr_line[i] !== J) se0_ok = 1'b0;
    checks++;
    if (se0_ok !== 1'b1 || tr_line[127] === S) begin
      errors++;
      $display("FAIL underrun_eop: eop_ok=%b line127=%b expected 1 and non-SE0",
               se0_ok, tr_line[127]);
    end
    checks++;
    if (tr_busy[151] !== 1'b1 || tr_busy[152] !== 1'b0 || tr_ready[152] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_idle: busy151=%b busy152=%b ready152=%b expected 1 0 1",
               tr_busy[151], tr_busy[152], tr_ready[152]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    logic quiet;
    start_byte(8'h55, 1'b1);
    repeat (82) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_plus, d_minus} !== J || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: line=%b busy=%b ready=%b expected %b 0 1",
               {d_plus, d_minus}, tx_busy, tx_ready, J);
    end
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== J || tx_busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL midrst_no_eop: idle_J=%b expected 1", quiet);
    end
    test_stuff_ff("midrst_ff");
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    test_reset();
    test_single_zero();
    test_stuff_ff("ff");
    test_back_to_back();
    test_underrun();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
